uart_rx: RTL and testbench



---
 rtl/uart_pkg.sv | 8 +
 rtl/uart_sync.sv | 13 +
 rtl/uart_rx.sv | 91 +++++++++
 tb/tb_uart_rx.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART frame constants, defaults and receiver state encoding
package uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_e;
    localparam int CLKS_PER_BIT_DEF = 16;
    localparam int DATA_W_DEF = 8;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT = 1'b1;
endpackage

// File: rtl/uart_sync.sv
// uart_sync: two-flop synchronizer for asynchronous inputs with a configurable reset value
module uart_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);
    logic [1:0] ff_q;
    always_ff @(posedge clk) ff_q <= rst ? {2{RST_VAL}} : {ff_q[0], d_i};
    assign q_o = ff_q[1];
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with valid/ready byte output and false-start, framing and overrun detection
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              frame_err,
    output logic              overrun,
    output logic              busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_W + 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_IDX = BW'(DATA_W - 1);
    state_e state_q;
    logic [CW-1:0] cnt_q;
    logic [BW-1:0] idx_q;
    logic [DATA_W-1:0] sh_q, data_q;
    logic rx_s, rx_d_q, valid_q, fe_q, ov_q;
    uart_sync #(.RST_VAL(1'b1)) u_sync (.clk(clk), .rst(rst), .d_i(rx), .q_o(rx_s));
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
            data_q  <= '0;
            rx_d_q  <= 1'b1;
            valid_q <= 1'b0;
            fe_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            rx_d_q <= rx_s;
            fe_q   <= 1'b0;
            ov_q   <= 1'b0;
            cnt_q  <= cnt_q + 1'b1;
            if (valid_q && rx_ready) valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (rx_d_q && !rx_s) state_q <= START;
                end
                START: if (cnt_q == HALF) begin
                    cnt_q   <= '0;
                    idx_q   <= '0;
                    state_q <= (rx_s == START_BIT) ? DATA : IDLE;
                end
                DATA: if (cnt_q == LAST) begin
                    cnt_q <= '0;
                    sh_q  <= (sh_q >> 1) | (DATA_W'(rx_s) << (DATA_W - 1));
                    idx_q <= idx_q + 1'b1;
                    if (idx_q == LAST_IDX) state_q <= STOP;
                end
                // stop sampled mid-bit, so IDLE re-arms half a bit early for back-to-back frames
                STOP: if (cnt_q == LAST) begin
                    cnt_q <= '0;
                    if (rx_s == STOP_BIT) begin
                        state_q <= IDLE;
                        if (!valid_q || rx_ready) begin
                            data_q  <= sh_q;
                            valid_q <= 1'b1;
                        end else begin
                            ov_q <= 1'b1;
                        end
                    end else begin
                        fe_q    <= 1'b1;
                        state_q <= WAIT_IDLE;
                    end
                end
                WAIT_IDLE: begin
                    cnt_q <= '0;
                    if (rx_s) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign frame_err = fe_q;
    assign overrun   = ov_q;
    assign busy      = state_q != IDLE;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized and directed bench for uart_rx against a frame-level timing model
module tb_uart_rx;
    import uart_pkg::*;
    localparam int N = CLKS_PER_BIT_DEF;
    localparam int W = DATA_W_DEF;
    // edges from the first edge sampling rx low (counted as edge 1) to the edge that raises rx_valid
    localparam int LAT = 2 + 1 + N / 2 + (W + 1) * N;

    logic clk = 1'b0, rst = 1'b1, rx = 1'b1, rx_ready = 1'b0;
    logic [W-1:0] rx_data;
    logic rx_valid, frame_err, overrun, busy;

    uart_rx #(.CLKS_PER_BIT(N), .DATA_W(W)) dut (
        .clk(clk), .rst(rst), .rx(rx), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .frame_err(frame_err), .overrun(overrun), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {int at; bit good; logic [W-1:0] d;} ev_t;
    ev_t evq[$];
    ev_t ev;
    int cyc = 0, vectors = 0, errs = 0, last_e0 = 0, c = 0;
    int rises = 0, fes = 0, ovs = 0, r0 = 0, f0 = 0, o0 = 0, bcnt = 0, bfirst = -1;
    bit chk_en = 1'b0, rnd_rdy = 1'b0, acc, full, good;
    logic m_valid = 1'b0, m_fe = 1'b0, m_ov = 1'b0, prev_v = 1'b0;
    logic [W-1:0] m_data = '0, last_rx = '0;

    // frame-level model: each frame resolves at a fixed edge, then the holding-register rules apply
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            m_valid = 1'b0; m_data = '0; m_fe = 1'b0; m_ov = 1'b0;
            evq.delete();
        end else begin
            acc = m_valid && rx_ready;
            full = m_valid && !rx_ready;
            m_fe = 1'b0; m_ov = 1'b0;
            if (acc) m_valid = 1'b0;
            if (evq.size() > 0 && evq[0].at == cyc) begin
                ev = evq.pop_front();
                if (!ev.good) m_fe = 1'b1;
                else if (full) m_ov = 1'b1;
                else begin m_data = ev.d; m_valid = 1'b1; end
            end
        end
    end

    always @(negedge clk) if (chk_en) begin
        vectors++;
        if ({rx_valid, rx_data, frame_err, overrun} !== {m_valid, m_data, m_fe, m_ov}) begin
            errs++;
            $display("FAIL cycle %0d: valid/data/ferr/ovr got %b/%h/%b/%b want %b/%h/%b/%b",
                     cyc, rx_valid, rx_data, frame_err, overrun, m_valid, m_data, m_fe, m_ov);
        end
        if (rx_valid && !prev_v) begin rises++; last_rx = rx_data; end
        if (frame_err) fes++;
        if (overrun) ovs++;
        prev_v = rx_valid;
    end

    always @(negedge clk) if (rnd_rdy) rx_ready = 1'($urandom_range(0, 1));

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h want %0h", nm, got, exp);
        end
    endtask

    task automatic at_neg(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // called on a negedge; a bad stop bit is held low for two bit times
    task automatic send(input logic [W-1:0] d, input bit ok, input int gap);
        rx = START_BIT;
        last_e0 = cyc + 1;
        evq.push_back('{at: last_e0 + LAT - 1, good: ok, d: d});
        repeat (N) @(negedge clk);
        for (int i = 0; i < W; i++) begin
            rx = d[i];
            repeat (N) @(negedge clk);
        end
        rx = ok ? STOP_BIT : START_BIT;
        repeat (ok ? N : 2 * N) @(negedge clk);
        rx = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        chk("reset valid", 32'(rx_valid), 0);
        chk("reset data", 32'(rx_data), 0);
        chk("reset ferr", 32'(frame_err), 0);
        chk("reset ovr", 32'(overrun), 0);
        chk("reset busy", 32'(busy), 0);
        chk_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rx_ready = 1'b1;
        repeat (3) @(negedge clk);

        fork
            send(8'hA5, 1'b1, 10);
            begin
                #1 c = last_e0 + LAT - 1;
                at_neg(c - 1);
                chk("a5 not yet valid", 32'(rx_valid), 0);
                at_neg(c);
                chk("a5 valid at latency", 32'(rx_valid), 1);
                chk("a5 data", 32'(rx_data), 32'h A5);
                at_neg(c + 1);
                chk("a5 valid one cycle", 32'(rx_valid), 0);
            end
        join
        chk("a5 no error pulses", 32'(fes + ovs), 0);

        r0 = rises;
        rx = 1'b0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (k == 3) rx = 1'b1;
            if (busy) begin bcnt++; if (bfirst < 0) bfirst = k; end
        end
        chk("glitch busy cycles", bcnt, 8);
        chk("glitch busy start", bfirst, 2);
        chk("glitch no byte", rises - r0, 0);
        chk("glitch no ferr", fes, 0);

        r0 = rises; f0 = fes;
        send(8'h3C, 1'b0, 30);
        chk("ferr pulses", fes - f0, 1);
        chk("ferr no byte", rises - r0, 0);
        send(8'h5A, 1'b1, 10);
        chk("after ferr byte", 32'(last_rx), 32'h5A);
        chk("after ferr count", rises - r0, 1);

        r0 = rises; o0 = ovs;
        rx_ready = 1'b0;
        send(8'h11, 1'b1, 0);
        send(8'h22, 1'b1, 20);
        chk("overrun pulses", ovs - o0, 1);
        chk("overrun held data", 32'(rx_data), 32'h11);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        chk("overrun drained", 32'(rx_valid), 0);
        chk("overrun 22 never seen", rises - r0, 1);

        send(8'h66, 1'b1, 5);
        r0 = rises; o0 = ovs;
        fork
            send(8'h77, 1'b1, 10);
            begin
                #1 c = last_e0 + LAT - 1;
                at_neg(c - 1);
                chk("simul held data", 32'(rx_data), 32'h66);
                rx_ready = 1'b1;
                at_neg(c);
                rx_ready = 1'b0;
                chk("simul valid", 32'(rx_valid), 1);
                chk("simul data", 32'(rx_data), 32'h77);
                chk("simul no ovr", 32'(overrun), 0);
            end
        join
        chk("simul no ovr total", ovs - o0, 0);

        f0 = fes; o0 = ovs;
        fork
            send(8'hFF, 1'b1, 10);
            begin
                #1 at_neg(last_e0 + 5 * N + 8);
                rst = 1'b1;
                repeat (2) @(negedge clk);
                rst = 1'b0;
                chk("midrst valid", 32'(rx_valid), 0);
                chk("midrst data", 32'(rx_data), 0);
                chk("midrst busy", 32'(busy), 0);
            end
        join
        rx_ready = 1'b1;
        r0 = rises;
        send(8'h81, 1'b1, 10);
        chk("after rst byte", 32'(last_rx), 32'h81);
        chk("after rst count", rises - r0, 1);
        chk("after rst no errors", (fes - f0) + (ovs - o0), 0);

        rnd_rdy = 1'b1;
        repeat (30) begin
            good = $urandom_range(0, 5) != 0;
            send(8'($urandom_range(0, 255)), good,
                 good ? int'($urandom_range(0, 12)) : N + int'($urandom_range(0, 12)));
        end
        rnd_rdy = 1'b0;
        @(negedge clk);
        rx_ready = 1'b1;
        repeat (40) @(negedge clk);
        chk("model queue drained", evq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
